// File: rtl/tenyr_trap_ctrl.sv
// Trap/interrupt controller: latches and masks requests, raises trap by fixed priority,
// snoops the trap-acknowledge store for EPC. Optional edge mode: TENYR_TRAP_CTRL_EDGE_EN.
`ifndef TRAP_ADDR
`define TRAP_ADDR 32'h0000_0100
`endif

module tenyr_trap_ctrl #(
  parameter int unsigned NIRQ     = 8,
  parameter logic [31:0] BASE     = 32'h0000_0200,
  parameter logic [31:0] ACK_ADDR = `TRAP_ADDR
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NIRQ-1:0] irq,
  input  logic            strobe,
  input  logic            mem_rw,
  input  logic [31:0]     d_addr,
  input  logic [31:0]     d_wdata,
  output logic [31:0]     d_rdata,
  output logic            d_oe,
  output logic            trap
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t          state, state_n;
  logic [NIRQ-1:0] pending, mask, req, irq_set, pend_n, ack_clr, w1c_bits;
  logic [CW-1:0]   cause, win;
  logic [31:0]     epc, off;
  logic            wr, rd_hit, ack, eoi, trap_n, ld_cause, ld_epc, found;

  assign off    = d_addr - BASE;
  assign wr     = strobe & mem_rw;
  assign rd_hit = reset_n & strobe & ~mem_rw & (off < 32'd4);
  assign ack    = wr & (d_addr == ACK_ADDR) & (state == ASSERT);
  assign eoi    = wr & (off == 32'd4);
  assign req    = pending & mask;

  // Zero-latency read path: the core latches d_data in the strobe cycle
  always_comb begin
    d_oe    = rd_hit;
    d_rdata = '0;
    if (rd_hit) begin
      case (off[1:0])
        2'd0:    d_rdata = 32'(pending);
        2'd1:    d_rdata = 32'(mask);
        2'd2:    d_rdata = 32'(cause);
        default: d_rdata = epc;
      endcase
    end
  end

`ifdef TENYR_TRAP_CTRL_EDGE_EN
  logic [NIRQ-1:0] sync1, sync2, prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign irq_set = sync2 & ~prev;
`else
  assign irq_set = irq;
`endif

  // Lowest set index wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NIRQ; i++) begin
      if (req[i] && !found) begin
        win   = CW'(i);
        found = 1'b1;
      end
    end
  end

  // New requests override both W1C and the acknowledge clear
  always_comb begin
    ack_clr  = '0;
    w1c_bits = '0;
    for (int i = 0; i < NIRQ; i++) begin
      ack_clr[i] = ack && (CW'(i) == cause);
    end
    if (wr && (off == 32'd0)) begin
      w1c_bits = d_wdata[NIRQ-1:0];
    end
    pend_n = (pending & ~w1c_bits & ~ack_clr) | irq_set;
  end

  always_comb begin
    state_n  = state;
    trap_n   = trap;
    ld_cause = 1'b0;
    ld_epc   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n  = ASSERT;
          trap_n   = 1'b1;
          ld_cause = 1'b1;
        end
      end
      ASSERT: begin
        if (ack) begin
          state_n = SERVICE;
          trap_n  = 1'b0;
          ld_epc  = 1'b1;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        trap_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      trap    <= 1'b0;
      pending <= '0;
      mask    <= '0;
      cause   <= '0;
      epc     <= '0;
    end else begin
      state   <= state_n;
      trap    <= trap_n;
      pending <= pend_n;
      if (wr && (off == 32'd1)) begin
        mask <= d_wdata[NIRQ-1:0];
      end
      if (ld_cause) begin
        cause <= win;
      end
      if (ld_epc) begin
        epc <= d_wdata;
      end
    end
  end

endmodule

// File: tb/tb_tenyr_trap_ctrl.sv
// Self-checking bench for tenyr_trap_ctrl (level-sensitive build): directed scenarios
// with literal expectations, then randomized traffic against a behavioural model.
module tb_tenyr_trap_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0200;
  localparam logic [31:0] ACK  = 32'h0000_0100;

  logic        clk;
  logic        reset_n;
  logic [7:0]  irq;
  logic        strobe;
  logic        mem_rw;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_oe;
  logic        trap;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 = no trap outstanding, 1 = trap raised to core, 2 = handler running
  logic [7:0]  m_pend;
  logic [7:0]  m_mask;
  int          m_cause;
  logic [31:0] m_epc;
  int          m_phase;
  bit          m_live = 0;

  tenyr_trap_ctrl #(.NIRQ(8), .BASE(BASE), .ACK_ADDR(ACK)) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq), .strobe(strobe), .mem_rw(mem_rw),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_oe(d_oe), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rn, input logic [7:0] i, input logic s, input logic rw,
                       input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    reset_n = rn; irq = i; strobe = s; mem_rw = rw; d_addr = a; d_wdata = w;
    #1;
  endtask

  // Compare the DUT against the model, then advance the model across the coming edge
  task automatic tick();
    logic [31:0] off, exp_rd;
    logic [7:0]  req, np;
    bit          exp_oe, wrh;
    off    = d_addr - BASE;
    exp_oe = reset_n && strobe && !mem_rw && (off < 4);
    exp_rd = 0;
    if (exp_oe) begin
      case (off)
        0: exp_rd = 32'(m_pend);
        1: exp_rd = 32'(m_mask);
        2: exp_rd = 32'(m_cause);
        default: exp_rd = m_epc;
      endcase
    end
    check("d_oe", 32'(d_oe), 32'(exp_oe));
    check("d_rdata", d_rdata, exp_rd);
    if (m_live) check("trap", 32'(trap), 32'(m_phase == 1));

    wrh = strobe && mem_rw;
    if (!reset_n) begin
      m_pend = 0; m_mask = 0; m_cause = 0; m_epc = 0; m_phase = 0; m_live = 1;
    end else begin
      req = m_pend & m_mask;
      np  = m_pend;
      if (wrh && off == 0) np = np & ~d_wdata[7:0];
      if (m_phase == 1 && wrh && d_addr == ACK) begin
        np[m_cause] = 1'b0;
        m_epc   = d_wdata;
        m_phase = 2;
      end else if (m_phase == 0 && req != 0) begin
        for (int k = 7; k >= 0; k--) if (req[k]) m_cause = k;
        m_phase = 1;
      end else if (m_phase == 2 && wrh && off == 4) begin
        m_phase = 0;
      end
      np = np | irq;
      if (wrh && off == 1) m_mask = d_wdata[7:0];
      m_pend = np;
    end
    @(posedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] w, input logic [7:0] i);
    drive(1'b1, i, 1'b1, 1'b1, a, w);
    tick();
  endtask

  task automatic idle(input logic [7:0] i);
    drive(1'b1, i, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b1, 8'h00, 1'b1, 1'b0, a, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; irq = 8'hFF; strobe = 1'b0; mem_rw = 1'b0; d_addr = 0; d_wdata = 0;

    // Reset with all requests high
    drive(1'b0, 8'hFF, 1'b1, 1'b0, BASE, 32'h0);
    check("rst_oe", 32'(d_oe), 32'h0);
    tick();
    drive(1'b0, 8'hFF, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rst_trap", 32'(trap), 32'h0);
    tick();
    idle(8'hFF);
    rd(BASE); check("pend_ff", d_rdata, 32'hFF); check("masked_no_trap", 32'(trap), 32'h0); tick();
    wr(BASE, 32'hFF, 8'h00);

    // Priority between irq[3] and irq[2]
    wr(BASE + 1, 32'h0C, 8'h00);
    idle(8'h0C);
    idle(8'h00);
    rd(BASE + 2); check("cause_2", d_rdata, 32'h2); check("trap_raised", 32'(trap), 32'h1); tick();
    wr(ACK, 32'h1234, 8'h00);
    rd(BASE + 3); check("epc_1234", d_rdata, 32'h1234); check("trap_acked", 32'(trap), 32'h0); tick();
    rd(BASE); check("pend_08", d_rdata, 32'h08); tick();

    // No nesting while in service; EOI re-raises
    wr(BASE + 1, 32'h0D, 8'h00);
    idle(8'h01);
    idle(8'h00);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0); check("nest_block", 32'(trap), 32'h0); tick();
    wr(BASE + 4, 32'h0, 8'h00);
    idle(8'h00);
    rd(BASE + 2); check("cause_0", d_rdata, 32'h0); check("eoi_retrap", 32'(trap), 32'h1); tick();
    wr(BASE + 1, 32'h0, 8'h00);
    wr(ACK, 32'h0, 8'h00);
    wr(BASE + 4, 32'h0, 8'h00);
    wr(BASE, 32'hFF, 8'h00);

    // Cause stays frozen while asserted
    wr(BASE + 1, 32'h20, 8'h00);
    idle(8'h20);
    idle(8'h00);
    rd(BASE + 2); check("cause_5", d_rdata, 32'h5); tick();
    wr(BASE + 1, 32'h00, 8'h00);
    wr(BASE, 32'h20, 8'h00);
    rd(BASE + 2); check("cause_frozen", d_rdata, 32'h5); check("trap_held", 32'(trap), 32'h1); tick();
    wr(ACK, 32'h55, 8'h00);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0); check("frozen_ack", 32'(trap), 32'h0); tick();
    wr(BASE + 4, 32'h0, 8'h00);

    // Read decode and set-wins-over-W1C
    wr(BASE + 1, 32'hA5, 8'h00);
    rd(BASE + 1); check("mask_oe", 32'(d_oe), 32'h1); check("mask_a5", d_rdata, 32'hA5); tick();
    rd(BASE + 4); check("eoi_no_oe", 32'(d_oe), 32'h0); tick();
    rd(BASE + 9); check("unmapped_no_oe", 32'(d_oe), 32'h0); tick();
    wr(BASE, 32'h40, 8'h40);
    rd(BASE); check("set_wins", d_rdata & 32'h40, 32'h40); tick();

    // Held level request re-sets after W1C
    idle(8'h02);
    wr(BASE, 32'h02, 8'h02);
    drive(1'b1, 8'h02, 1'b1, 1'b0, BASE, 32'h0); check("level_reset", d_rdata & 32'h02, 32'h02); tick();

    // Randomized traffic
    drive(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] a;
      logic [7:0]  i;
      case ($urandom_range(0, 7))
        0, 1:    a = ACK;
        2:       a = BASE;
        3:       a = BASE + 1;
        4:       a = BASE + 2 + 32'($urandom_range(0, 1));
        5:       a = BASE + 4;
        6:       a = BASE + 9;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       i = 8'(1 << $urandom_range(0, 7));
        1:       i = 8'($urandom);
        default: i = 8'h00;
      endcase
      drive(logic'($urandom_range(0, 149) != 0), i, logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)), a, $urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
